// File: rtl/iec_pkg.sv
// iec_pkg: shared constants for the IEC bus front end.
// Filter counter width, FILT_LEN range check, default line level, channel map.
package iec_pkg;

  localparam int CNT_W    = 4;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = (1 << CNT_W) - 1;

  // Released bus line reads as 1.
  localparam logic RST_BIT = 1'b1;

  localparam int ATN_IDX  = 0;
  localparam int CLK_IDX  = 1;
  localparam int DATA_IDX = 2;

  function automatic bit filt_len_ok(input int n);
    return (n >= FILT_MIN) && (n <= FILT_MAX);
  endfunction

endpackage

// File: rtl/iec_line_filter.sv
// iec_line_filter: one bus line - 2-flop sync, run-length glitch filter,
// edge pulses and sticky edge flag. Optional glitch counter (IEC_GLITCH_CNT_EN).
// Ports: clk32, reset_n, line_i, evt_pol, evt_clr -> line_q, rise_o, fall_o,
// evt_o; glitch_clr -> glitch_cnt[7:0] when IEC_GLITCH_CNT_EN is defined.
module iec_line_filter
  import iec_pkg::*;
#(
  parameter int   FILT_LEN = 2,
  parameter logic RST_VAL  = 1'b1
) (
  input  logic       clk32,
  input  logic       reset_n,
  input  logic       line_i,
  input  logic       evt_pol,
  input  logic       evt_clr,
`ifdef IEC_GLITCH_CNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt,
`endif
  output logic       line_q,
  output logic       rise_o,
  output logic       fall_o,
  output logic       evt_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FILT_LEN - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             take;

  assign diff = s2 ^ line_q;
  assign take = diff && (cnt == LAST);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= RST_VAL;
      s2     <= RST_VAL;
      line_q <= RST_VAL;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      evt_o  <= 1'b0;
    end else begin
      s1     <= line_i;
      s2     <= s1;
      rise_o <= take & s2;
      fall_o <= take & ~s2;
      // A set from the selected edge pulse beats a same-cycle clear.
      evt_o  <= (evt_o & ~evt_clr) |
                (evt_pol ? rise_o : fall_o);
      if (!diff || take)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (take)
        line_q <= s2;
    end
  end

`ifdef IEC_GLITCH_CNT_EN
  // Count aborted in progress, line_q untouched: a rejected pulse.
  logic rejected;
  assign rejected = ~diff & (cnt != '0);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n)
      glitch_cnt <= '0;
    else if (glitch_clr)
      glitch_cnt <= '0;
    else if (rejected && (glitch_cnt != 8'hFF))
      glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: rtl/iec_bus_frontend.sv
// iec_bus_frontend: phi2 strobe divider, NCH filtered bus lines, ATN auto-ack.
// Ports: clk32, reset_n, run, line_i, evt_pol, evt_clr, atna, data_loc in;
// line_q, rise_o, fall_o, evt_o, phi_r, phi_f, data_pull out.
// IEC_GLITCH_CNT_EN adds glitch_clr in and glitch_cnt[NCH*8-1:0] out.
module iec_bus_frontend
  import iec_pkg::*;
#(
  parameter int             CLK_DIV  = 32,
  parameter int             NCH      = 3,
  parameter int             FILT_LEN = 2,
  parameter int             ATN_CH   = ATN_IDX,
  parameter logic [NCH-1:0] RST_LVL  = {NCH{RST_BIT}}
) (
  input  logic             clk32,
  input  logic             reset_n,
  input  logic             run,
  input  logic [NCH-1:0]   line_i,
  input  logic [NCH-1:0]   evt_pol,
  input  logic [NCH-1:0]   evt_clr,
  input  logic             atna,
  input  logic             data_loc,
`ifdef IEC_GLITCH_CNT_EN
  input  logic             glitch_clr,
  output logic [NCH*8-1:0] glitch_cnt,
`endif
  output logic [NCH-1:0]   line_q,
  output logic [NCH-1:0]   rise_o,
  output logic [NCH-1:0]   fall_o,
  output logic [NCH-1:0]   evt_o,
  output logic             phi_r,
  output logic             phi_f,
  output logic             data_pull
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF =
    DIV_W'(CLK_DIV / 2);

  if (!filt_len_ok(FILT_LEN) || CLK_DIV < 4 ||
      (CLK_DIV % 2) != 0 || NCH < 1 ||
      ATN_CH < 0 || ATN_CH >= NCH) begin : g_bad_cfg
    $error("iec_bus_frontend: illegal parameters");
  end

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      div       <= '0;
      phi_r     <= 1'b0;
      phi_f     <= 1'b0;
      data_pull <= 1'b0;
    end else begin
      phi_r <= run && (div == '0);
      phi_f <= run && (div == DIV_HALF);
      if (run)
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      // Pull DATA while ATN level disagrees with the VIA ack bit.
      data_pull <= data_loc |
                   (atna ^ ~line_q[ATN_CH]);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_line
    iec_line_filter #(
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (RST_LVL[g])
    ) u_filt (
      .clk32      (clk32),
      .reset_n    (reset_n),
      .line_i     (line_i[g]),
      .evt_pol    (evt_pol[g]),
      .evt_clr    (evt_clr[g]),
`ifdef IEC_GLITCH_CNT_EN
      .glitch_clr (glitch_clr),
      .glitch_cnt (glitch_cnt[8*g +: 8]),
`endif
      .line_q     (line_q[g]),
      .rise_o     (rise_o[g]),
      .fall_o     (fall_o[g]),
      .evt_o      (evt_o[g])
    );
  end

endmodule

// File: tb/tb_iec_bus_frontend.sv
// tb_iec_bus_frontend: random + directed bench with a window-based
// reference model of the divider, filters, flags and auto-ack.
module tb_iec_bus_frontend;

  localparam int CLK_DIV  = 32;
  localparam int NCH      = 3;
  localparam int FILT_LEN = 2;
  localparam int ATN_CH   = 0;
  localparam logic [NCH-1:0] RST_LVL = 3'b111;
  localparam int HL = 20;

  logic           clk32;
  logic           reset_n;
  logic           run;
  logic [NCH-1:0] line_i;
  logic [NCH-1:0] evt_pol;
  logic [NCH-1:0] evt_clr;
  logic           atna;
  logic           data_loc;
  logic           glitch_clr;
  logic [NCH-1:0] line_q;
  logic [NCH-1:0] rise_o;
  logic [NCH-1:0] fall_o;
  logic [NCH-1:0] evt_o;
  logic           phi_r;
  logic           phi_f;
  logic           data_pull;
`ifdef IEC_GLITCH_CNT_EN
  logic [NCH*8-1:0] glitch_cnt;
`endif

  iec_bus_frontend #(
    .CLK_DIV  (CLK_DIV),
    .NCH      (NCH),
    .FILT_LEN (FILT_LEN),
    .ATN_CH   (ATN_CH),
    .RST_LVL  (RST_LVL)
  ) dut (
    .clk32      (clk32),
    .reset_n    (reset_n),
    .run        (run),
    .line_i     (line_i),
    .evt_pol    (evt_pol),
    .evt_clr    (evt_clr),
    .atna       (atna),
    .data_loc   (data_loc),
`ifdef IEC_GLITCH_CNT_EN
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt),
`endif
    .line_q     (line_q),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .evt_o      (evt_o),
    .phi_r      (phi_r),
    .phi_f      (phi_f),
    .data_pull  (data_pull)
  );

  always #5 clk32 = ~clk32;

  int n_chk;
  int n_pass;
  bit chk_en;

  // Model state: ph = run-cycles mod CLK_DIV; rh[k] = line_i k edges ago.
  int             ph;
  bit             m_pr;
  bit             m_pf;
  logic [NCH-1:0] m_q;
  logic [NCH-1:0] m_rise;
  logic [NCH-1:0] m_fall;
  logic [NCH-1:0] m_evt;
  bit             m_pull;
  logic [NCH-1:0] rh [HL];
  int             m_gc [NCH];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
  endtask

  task automatic model_reset();
    ph     = 0;
    m_pr   = 0;
    m_pf   = 0;
    m_q    = RST_LVL;
    m_rise = '0;
    m_fall = '0;
    m_evt  = '0;
    m_pull = 0;
    for (int k = 0; k < HL; k++) rh[k] = RST_LVL;
    for (int i = 0; i < NCH; i++) m_gc[i] = 0;
  endtask

  // One clock edge: line level accepted once the last FILT_LEN
  // synchronised samples (2 edges old) all disagree with it.
  task automatic model_step();
    logic [NCH-1:0] oq;
    logic [NCH-1:0] orr;
    logic [NCH-1:0] ofl;
    bit tk;
    oq  = m_q;
    orr = m_rise;
    ofl = m_fall;
    m_pr = run && (ph == 0);
    m_pf = run && (ph == CLK_DIV / 2);
    if (run) ph = (ph + 1) % CLK_DIV;
    for (int k = HL - 1; k > 0; k--) rh[k] = rh[k-1];
    rh[0] = line_i;
    for (int i = 0; i < NCH; i++) begin
      tk = 1'b1;
      for (int k = 2; k <= FILT_LEN + 1; k++)
        if (rh[k][i] == oq[i]) tk = 1'b0;
      m_rise[i] = tk && rh[2][i];
      m_fall[i] = tk && !rh[2][i];
      if (tk) m_q[i] = rh[2][i];
      if (glitch_clr)
        m_gc[i] = 0;
      else if (!tk && rh[2][i] == oq[i] &&
               rh[3][i] != oq[i] && m_gc[i] < 255)
        m_gc[i]++;
    end
    m_evt  = (m_evt & ~evt_clr) |
             (evt_pol & orr) | (~evt_pol & ofl);
    m_pull = data_loc | (atna ^ ~oq[ATN_CH]);
  endtask

  task automatic tick();
    @(posedge clk32);
    #2;
    model_step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":line_q"}, line_q, RST_LVL);
    check({tag, ":rise"}, rise_o, 0);
    check({tag, ":fall"}, fall_o, 0);
    check({tag, ":evt"}, evt_o, 0);
    check({tag, ":phi_r"}, phi_r, 0);
    check({tag, ":phi_f"}, phi_f, 0);
    check({tag, ":pull"}, data_pull, 0);
  endtask

  task automatic do_reset();
    chk_en = 0;
    #1 reset_n = 0;
    #1 check_reset("mid_rst");
    model_reset();
    repeat (2) @(negedge clk32);
    #1 reset_n = 1;
    chk_en = 1;
  endtask

  always @(negedge clk32) begin
    if (chk_en) begin
      check("line_q", line_q, m_q);
      check("rise_o", rise_o, m_rise);
      check("fall_o", fall_o, m_fall);
      check("evt_o", evt_o, m_evt);
      check("phi_r", phi_r, m_pr);
      check("phi_f", phi_f, m_pf);
      check("data_pull", data_pull, m_pull);
`ifdef IEC_GLITCH_CNT_EN
      for (int i = 0; i < NCH; i++)
        check("glitch_cnt", glitch_cnt[8*i +: 8],
              64'(m_gc[i]));
`endif
    end
  end

  initial begin
    bit rst_done;
    clk32      = 0;
    reset_n    = 0;
    run        = 1;
    line_i     = '1;
    evt_pol    = '0;
    evt_clr    = '0;
    atna       = 0;
    data_loc   = 0;
    glitch_clr = 0;
    chk_en     = 0;
    n_chk      = 0;
    n_pass     = 0;
    rst_done   = 0;
    model_reset();
    repeat (2) @(posedge clk32);
    #2 check_reset("por");
    @(negedge clk32);
    #1 reset_n = 1;
    chk_en = 1;

    for (int c = 1; c <= 112; c++) begin
      tick();
      case (c)
        1: begin
          check("phi_r@1", phi_r, 1);
          check("phi_f@1", phi_f, 0);
        end
        10: line_i[1] = 1'b0;
        13: check("q1@13", line_q[1], 1);
        14: begin
          check("q1@14", line_q[1], 0);
          check("fall1@14", fall_o[1], 1);
        end
        15: check("fall1@15", fall_o[1], 0);
        17: check("phi_f@17", phi_f, 1);
        20: line_i[2] = 1'b0;
        21: line_i[2] = 1'b1;
        26: check("q2_pulse", line_q[2], 1);
        33: check("phi_r@33", phi_r, 1);
        39: run = 1'b0;
        49: begin
          check("phi_f@49", phi_f, 0);
          run = 1'b1;
        end
        59: check("phi_f@59", phi_f, 1);
        75: check("phi_r@75", phi_r, 1);
        80: line_i[0] = 1'b0;
        84: check("pull@84", data_pull, 0);
        85: begin
          check("pull@85", data_pull, 1);
          check("evt0@85", evt_o[0], 1);
        end
        86: atna = 1'b1;
        87: check("pull@87", data_pull, 0);
        90: line_i[0] = 1'b1;
        100: line_i[0] = 1'b0;
        104: begin
          check("fall0@104", fall_o[0], 1);
          evt_clr[0] = 1'b1;
        end
        105: begin
          check("evt0_setwins", evt_o[0], 1);
          evt_clr[0] = 1'b0;
        end
        110: evt_clr[0] = 1'b1;
        111: begin
          check("evt0_clr", evt_o[0], 0);
          evt_clr[0] = 1'b0;
        end
        default: ;
      endcase
    end

`ifdef IEC_GLITCH_CNT_EN
    for (int p = 0; p < 300; p++) begin
      line_i[2] = 1'b0;
      tick();
      line_i[2] = 1'b1;
      tick();
    end
    repeat (4) tick();
    check("gcnt2_sat", glitch_cnt[23:16], 8'd255);
    check("gq2_hold", line_q[2], 1);
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    check("gcnt2_clr", glitch_cnt[23:16], 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_done && c > 1000 && m_pf) begin
        check("phi_f_pre_rst", phi_f, 1);
        do_reset();
        rst_done = 1;
      end
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 5) == 0)
          line_i[i] = ~line_i[i];
        if ($urandom_range(0, 19) == 0)
          evt_pol[i] = ~evt_pol[i];
        evt_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 9) == 0) atna = ~atna;
      if ($urandom_range(0, 9) == 0)
        data_loc = ~data_loc;
      glitch_clr = ($urandom_range(0, 63) == 0);
    end
    glitch_clr = 1'b0;
    repeat (3) tick();
    @(negedge clk32);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iec_bus_frontend.md
Name: iec_bus_frontend

Overview:
Parametrised front end between the raw IEC serial bus and a drive's CPU/VIA core. It generates the phi2 rising/falling clock-enable strobes, synchronises and glitch-filters NCH bus lines, produces per-line edge pulses and sticky edge flags for interrupt use, and computes the hardware ATN auto-acknowledge DATA pull. It is the generalised successor of the fixed 3-line, /32 logic inside the drive core. Multiple drive instances can share one bus.

Parameters:
CLK_DIV, 32, clk32 cycles per phi2 period; even, >=4.
NCH, 3, number of bus lines filtered; NCH>=1.
FILT_LEN, 2, consecutive stable synchronised samples needed to accept a new level; 1..15.
ATN_CH, 0, index of the ATN line within line_i.
RST_LVL, all ones, NCH-bit reset level of the filtered lines (released bus = 1).

Ports:
clk32  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
run  in  1  1 = divider advances; 0 = divider frozen and no strobes.
line_i  in  NCH  raw bus levels (1 = released).
line_q  out  NCH  filtered line levels.
rise_o  out  NCH  one-cycle pulse on a filtered 0->1 transition.
fall_o  out  NCH  one-cycle pulse on a filtered 1->0 transition.
evt_pol  in  NCH  per-line sticky-flag polarity: 1 = rise, 0 = fall.
evt_clr  in  NCH  per-line sticky-flag clear.
evt_o  out  NCH  sticky edge flags.
phi_r  out  1  phi2 rising strobe.
phi_f  out  1  phi2 falling strobe.
atna  in  1  ATN-acknowledge bit from the VIA port register.
data_loc  in  1  local DATA pull request from the VIA.
data_pull  out  1  DATA pull to the bus (1 = pull low).

Behaviour:
- Reset (async, reset_n=0): div=0, phi_r=phi_f=0, sync flops and line_q=RST_LVL, filter counters=0, rise_o=fall_o=evt_o=0, data_pull=0. Outputs are valid from the first clock after reset_n deasserts.
- Divider: div counts 0..CLK_DIV-1 and wraps only while run=1.
  - phi_r is registered high for one cycle after div==0.
  - phi_f is registered high for one cycle after div==CLK_DIV/2.
  - phi_r and phi_f are never high together.
  - run=0 freezes div and forces both strobes to 0 the next cycle. run=1 resumes from the held div.
- Filter, per line i: line_i passes through a 2-flop synchroniser s1->s2. A 4-bit counter cnt behaves as follows:
  - s2==line_q: cnt<=0.
  - s2!=line_q and cnt<FILT_LEN-1: cnt<=cnt+1.
  - s2!=line_q and cnt==FILT_LEN-1: line_q<=s2, cnt<=0.
  - Latency: a clean input step appears on line_q exactly FILT_LEN+2 clock edges after it is first sampled.
  - A pulse lasting fewer than FILT_LEN cycles at s2 never reaches line_q.
- Edges: rise_o/fall_o are registered in the same cycle line_q changes and last exactly one cycle.
- Sticky flags: evt_o[i] is set on the edge selected by evt_pol[i] and cleared by evt_clr[i].
  - If set and clear occur in the same cycle, set wins.
  - Changing evt_pol does not alter the current flag.
- Auto-ack: data_pull <= data_loc | (atna ^ ~line_q[ATN_CH]), registered, 1 cycle after line_q/atna/data_loc.
- The filter does not depend on run; lines are tracked even while the CPU is paused.

Optional Feature:
IEC_GLITCH_CNT_EN
- Defined: adds output glitch_cnt (NCH*8 bits, line i at bits [8i+7:8i]) and input glitch_clr (1 bit).
  - A line's counter increments (saturating at 255) whenever that line's cnt returns to 0 from a non-zero value without line_q changing, i.e. a rejected pulse.
  - glitch_clr zeroes all counters; on a simultaneous increment, clear wins.
  - Counters reset to 0.
- Undefined: no port, no logic.

Decomposition:
- Package iec_pkg holds:
  - CNT_W=4;
  - the FILT_LEN legal range check constant;
  - the default RST_LVL;
  - the ATN/CLK/DATA channel index localparams (0/1/2).
- One sub-module, iec_line_filter: one line, containing the synchroniser, counter, line_q, rise/fall, sticky flag and optional glitch counter. It is instantiated NCH times through a generate loop. The divider and auto-ack stay in the top level.

Test Plan:
- Divider: CLK_DIV=32, run=1 from reset -> phi_r on cycles 1,33,65...; phi_f on 17,49...; run=0 for 10 cycles -> no strobes, and the phase continues unchanged afterwards.
- Filter: FILT_LEN=2, line_i[1] steps 1->0 at cycle 10 -> line_q[1]=0 and fall_o[1]=1 at cycle 14 only; a 1-cycle low pulse -> line_q stays 1 and rise/fall stay 0.
- Sticky flag: evt_pol[0]=0, ATN falls -> evt_o[0]=1 held; evt_clr[0] coincident with a second fall -> evt_o[0] stays 1; a later lone clear -> 0.
- Auto-ack: atna=0, data_loc=0, ATN filtered 1->0 -> data_pull=1 one cycle after line_q; atna=1 -> data_pull=0.
- Reset mid-operation: reset_n low during a filter count and while phi_f is high -> all outputs immediately at reset values; line_q=RST_LVL.
- IEC_GLITCH_CNT_EN: 300 one-cycle glitches on line 2 -> glitch_cnt[23:16]=255, line_q[2] unchanged; glitch_clr -> 0.
